// File: rtl/bbprx_packer.sv
// Receive sample packer: serialises multi-channel strobes into a word RAM and
// exposes only whole, untainted packets to the reader.
module bbprx_packer #(
   parameter int WIDTH      = 16,
   parameter int NCHAN      = 2,
   parameter int DEPTH_LOG2 = 12,
   parameter int PKT_WORDS  = 256
) (
   input  logic                     rxclk,
   input  logic                     reset,
   input  logic                     rxstrobe,
   input  logic [NCHAN*WIDTH-1:0]   data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     pkt_rdy,
   output logic [DEPTH_LOG2:0]      level,
   input  logic                     clear_status,
   output logic                     rx_overrun,
   output logic [15:0]              drop_count
);

   localparam int PTRW  = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam int PCW   = $clog2(PKT_WORDS + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   localparam logic [PTRW-1:0] DEPTH_P   = PTRW'(DEPTH);
   localparam logic [PTRW-1:0] NCHAN_P   = PTRW'(NCHAN);
   localparam logic [PTRW-1:0] PKT_P     = PTRW'(PKT_WORDS);
   localparam logic [CHW-1:0]  LAST_CH   = CHW'(NCHAN - 1);
   localparam logic [PCW-1:0]  LAST_WORD = PCW'(PKT_WORDS - 1);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   logic [0:0]             state_q, state_d;
   logic [CHW-1:0]         chan_q, chan_d;
   logic [NCHAN*WIDTH-1:0] lat_q, lat_d;
   logic [PTRW-1:0]        rptr_q, rptr_d;
   logic [PTRW-1:0]        cptr_q, cptr_d;
   logic [PTRW-1:0]        tptr_q, tptr_d;
   logic [PCW-1:0]         pcnt_q, pcnt_d;
   logic                   taint_q, taint_d;
   logic [WIDTH-1:0]       rd_data_q, rd_data_d;
   logic                   ovr_q, ovr_d;
   logic [15:0]            drop_q, drop_d;

   logic [PTRW-1:0]        used_s;
   logic [PTRW-1:0]        free_s;
   logic [PTRW-1:0]        level_s;
   logic                   accept_s;
   logic                   reject_s;
   logic                   wr_en_s;
   logic                   rd_ok_s;
   logic [WIDTH-1:0]       wr_data_s;

   // Acceptance uses the read pointer before this cycle's pop.
   always_comb begin
      used_s    = tptr_q - rptr_q;
      free_s    = DEPTH_P - used_s;
      level_s   = cptr_q - rptr_q;
      accept_s  = rxstrobe && (state_q == S_IDLE) && (free_s >= NCHAN_P);
      reject_s  = rxstrobe && !accept_s;
      wr_en_s   = (state_q == S_SHIFT) && !reset;
      rd_ok_s   = rd_en && (level_s != {PTRW{1'b0}});
      wr_data_s = lat_q[chan_q*WIDTH +: WIDTH];
   end

   // Sequencer: latch a strobe, then emit its channels one per cycle.
   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      lat_d   = lat_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d = S_SHIFT;
               chan_d  = {CHW{1'b0}};
               lat_d   = data;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            chan_d = chan_q + CHW'(1);
            if (chan_q == LAST_CH) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Write pointer, packet counter and commit/rollback on the last word.
   always_comb begin
      tptr_d  = tptr_q;
      cptr_d  = cptr_q;
      pcnt_d  = pcnt_q;
      taint_d = taint_q | reject_s;
      if (wr_en_s) begin
         tptr_d = tptr_q + PTRW'(1);
         if (pcnt_q == LAST_WORD) begin
            pcnt_d = {PCW{1'b0}};
            if (taint_d) begin
               tptr_d  = cptr_q;
               taint_d = 1'b0;
            end else begin
               cptr_d = tptr_q + PTRW'(1);
            end
         end else begin
            pcnt_d = pcnt_q + PCW'(1);
         end
      end else begin
         pcnt_d = pcnt_q;
      end
   end

   // Read port: one-cycle latency, holds when idle.
   always_comb begin
      rptr_d    = rptr_q;
      rd_data_d = rd_data_q;
      if (rd_ok_s) begin
         rptr_d    = rptr_q + PTRW'(1);
         rd_data_d = mem[rptr_q[DEPTH_LOG2-1:0]];
      end else begin
         rptr_d = rptr_q;
      end
   end

   // Drop accounting: a drop outranks a coincident clear.
   always_comb begin
      ovr_d  = ovr_q;
      drop_d = drop_q;
      if (reject_s) begin
         ovr_d  = 1'b1;
         drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
      end else if (clear_status) begin
         ovr_d  = 1'b0;
         drop_d = 16'd0;
      end else begin
         ovr_d  = ovr_q;
      end
   end

   // State registers.
   always_ff @(posedge rxclk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         chan_q    <= {CHW{1'b0}};
         lat_q     <= {(NCHAN*WIDTH){1'b0}};
         rptr_q    <= {PTRW{1'b0}};
         cptr_q    <= {PTRW{1'b0}};
         tptr_q    <= {PTRW{1'b0}};
         pcnt_q    <= {PCW{1'b0}};
         taint_q   <= 1'b0;
         rd_data_q <= {WIDTH{1'b0}};
         ovr_q     <= 1'b0;
         drop_q    <= 16'd0;
      end else begin
         state_q   <= state_d;
         chan_q    <= chan_d;
         lat_q     <= lat_d;
         rptr_q    <= rptr_d;
         cptr_q    <= cptr_d;
         tptr_q    <= tptr_d;
         pcnt_q    <= pcnt_d;
         taint_q   <= taint_d;
         rd_data_q <= rd_data_d;
         ovr_q     <= ovr_d;
         drop_q    <= drop_d;
      end
   end

   // Sample RAM write port.
   always_ff @(posedge rxclk) begin
      if (wr_en_s) begin
         mem[tptr_q[DEPTH_LOG2-1:0]] <= wr_data_s;
      end
   end

   assign rd_data    = rd_data_q;
   assign level      = level_s;
   assign pkt_rdy    = (level_s >= PKT_P);
   assign rx_overrun = ovr_q;
   assign drop_count = drop_q;

endmodule
